// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, FSM states and
// instruction field helpers.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_LDI  = 4'd6;
  localparam logic [3:0] OP_JMP  = 4'd7;
  localparam logic [3:0] OP_JZ   = 4'd8;
  localparam logic [3:0] OP_HALT = 4'd9;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  // Extract `width` bits starting at `lsb` from a zero-extended instruction.
  function automatic logic [63:0] field_bits(input logic [63:0] instr,
                                             input int lsb, input int width);
    return (instr >> lsb) & ((64'd1 << width) - 64'd1);
  endfunction

  function automatic logic op_is_alu(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  function automatic logic op_writes_reg(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_LDI);
  endfunction

endpackage

// File: rtl/cpu_core_regfile.sv
// Register file: 2**SEL_W words, two operand read ports, a debug read port,
// one synchronous write port, async clear; r0 is hardwired to zero.
module regfile #(
  parameter int W     = 8,
  parameter int SEL_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             we,
  input  logic [SEL_W-1:0] wsel,
  input  logic [W-1:0]     wdata,
  input  logic [SEL_W-1:0] rsel_a,
  output logic [W-1:0]     rdata_a,
  input  logic [SEL_W-1:0] rsel_b,
  output logic [W-1:0]     rdata_b,
  input  logic [SEL_W-1:0] dbg_sel,
  output logic [W-1:0]     dbg_data
);

  localparam int NREG = 2**SEL_W;

  logic [W-1:0] mem [NREG];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
    end else if (we && (wsel != '0)) begin
      mem[wsel] <= wdata;
    end
  end

  assign rdata_a  = (rsel_a  == '0) ? '0 : mem[rsel_a];
  assign rdata_b  = (rsel_b  == '0) ? '0 : mem[rsel_b];
  assign dbg_data = (dbg_sel == '0) ? '0 : mem[dbg_sel];

endmodule

// File: rtl/cpu_core.sv
// Multi-cycle fetch/execute core: fetches over a req/ack handshake, then
// commits register write, flags and PC in a single EXEC cycle.
module cpu_core
  import cpu_pkg::*;
#(
  parameter int W     = 8,
  parameter int SEL_W = 4,
  parameter int OP_W  = 4,
  parameter int IW    = OP_W + 2*SEL_W + W
) (
  input  logic             clock,
  input  logic             reset_n,
  output logic             imem_req,
  output logic [W-1:0]     imem_addr,
  input  logic             imem_ack,
  input  logic [IW-1:0]    imem_data,
  output logic [W-1:0]     pc,
  output logic             flag_z,
  output logic             flag_c,
  output logic             halted,
  input  logic [SEL_W-1:0] dbg_sel,
  output logic [W-1:0]     dbg_data
);

  state_t           state, state_nxt;
  logic [IW-1:0]    instr_p1;
  logic [OP_W-1:0]  op;
  logic [SEL_W-1:0] z_sel, x_sel, y_sel;
  logic [W-1:0]     arg, x_val, y_val, alu_res, pc_nxt;
  logic [W:0]       sum_ext, diff_ext;
  logic             alu_c, wr_en, c_en;

  assign op    = OP_W'(field_bits(64'(instr_p1), IW-OP_W, OP_W));
  assign z_sel = SEL_W'(field_bits(64'(instr_p1), W+SEL_W, SEL_W));
  assign x_sel = SEL_W'(field_bits(64'(instr_p1), W, SEL_W));
  assign arg   = W'(field_bits(64'(instr_p1), 0, W));
  assign y_sel = arg[SEL_W-1:0];

  regfile #(.W(W), .SEL_W(SEL_W)) u_regfile (
    .clock    (clock),
    .reset_n  (reset_n),
    .we       (wr_en),
    .wsel     (z_sel),
    .wdata    (alu_res),
    .rsel_a   (x_sel),
    .rdata_a  (x_val),
    .rsel_b   (y_sel),
    .rdata_b  (y_val),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  // The extra MSB is the carry for ADD and the borrow (x<y) for SUB.
  assign sum_ext  = {1'b0, x_val} + {1'b0, y_val};
  assign diff_ext = {1'b0, x_val} - {1'b0, y_val};

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc + W'(1);
    alu_res   = '0;
    alu_c     = 1'b0;
    wr_en     = 1'b0;
    c_en      = 1'b0;
    case (state)
      S_FETCH: if (imem_ack) state_nxt = S_EXEC;
      S_EXEC: begin
        state_nxt = S_FETCH;
        wr_en     = op_writes_reg(op);
        c_en      = op_is_alu(op);
        case (op)
          OP_ADD:  {alu_c, alu_res} = sum_ext;
          OP_SUB:  {alu_c, alu_res} = diff_ext;
          OP_AND:  alu_res = x_val & y_val;
          OP_OR:   alu_res = x_val | y_val;
          OP_XOR:  alu_res = x_val ^ y_val;
          OP_LDI:  alu_res = arg;
          OP_JMP:  pc_nxt = arg;
          OP_JZ:   if (x_val == '0) pc_nxt = arg;
          OP_HALT: begin
            pc_nxt    = pc;
            state_nxt = S_HALTED;
          end
          default: ;
        endcase
      end
      S_HALTED: ;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_FETCH;
      pc     <= '0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_EXEC) pc <= pc_nxt;
      if (wr_en) flag_z <= (alu_res == '0);
      if (c_en)  flag_c <= alu_c;
    end
  end

  // Fetch stage boundary: instruction word captured on an accepted fetch.
  always_ff @(posedge clock) begin
    if ((state == S_FETCH) && imem_ack) instr_p1 <= imem_data;
  end

  assign imem_req  = reset_n && (state == S_FETCH);
  assign imem_addr = pc;
  assign halted    = (state == S_HALTED);

endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: directed programs plus random straight-line programs
// checked against an instruction-level reference model.
module tb_cpu_core;

  localparam int W     = 8;
  localparam int SEL_W = 4;
  localparam int OP_W  = 4;
  localparam int IW    = OP_W + 2*SEL_W + W;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             imem_req;
  logic [W-1:0]     imem_addr;
  logic             imem_ack;
  logic [IW-1:0]    imem_data;
  logic [W-1:0]     pc;
  logic             flag_z, flag_c, halted;
  logic [SEL_W-1:0] dbg_sel = '0;
  logic [W-1:0]     dbg_data;

  always #5 clock = ~clock;

  cpu_core #(.W(W), .SEL_W(SEL_W), .OP_W(OP_W), .IW(IW)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_data (imem_data),
    .pc        (pc),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .halted    (halted),
    .dbg_sel   (dbg_sel),
    .dbg_data  (dbg_data)
  );

  // Instruction memory with a configurable number of wait cycles per fetch.
  logic [IW-1:0] imem [256];
  int ack_delay = 0;
  int wait_cnt  = 0;
  assign imem_ack  = imem_req && (wait_cnt >= ack_delay);
  assign imem_data = imem[imem_addr];
  always @(posedge clock) begin
    if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else                       wait_cnt <= 0;
  end

  int n_checks = 0;
  int n_fails  = 0;
  int cycles;
  logic [W-1:0] trace [$];

  // Reference model state
  int   m_regs [16];
  int   m_pc, m_steps;
  logic m_z, m_c;

  function automatic logic [IW-1:0] enc(input int op, input int z, input int x, input int arg);
    return {4'(op), 4'(z), 4'(x), 8'(arg)};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 256; i++) imem[i] = '0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic run_prog(input int delay, input int budget);
    logic         prev_wait;
    logic [W-1:0] prev_addr;
    ack_delay = delay;
    apply_reset();
    cycles    = 0;
    trace.delete();
    prev_wait = 1'b0;
    prev_addr = '0;
    while (!halted && cycles < budget) begin
      if (prev_wait) begin
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== prev_addr) begin
          n_fails++;
          $display("FAIL fetch_hold: req=%b addr=%0h, expected req=1 addr=%0h", imem_req, imem_addr, prev_addr);
        end
      end
      prev_wait = imem_req && !imem_ack;
      prev_addr = imem_addr;
      if (imem_req && imem_ack) trace.push_back(imem_addr);
      @(posedge clock);
      #1;
      cycles++;
    end
    n_checks++;
    if (halted !== 1'b1) begin
      n_fails++;
      $display("FAIL halt_timeout: halted=%b after %0d cycles, expected 1", halted, cycles);
    end
  endtask

  task automatic model_run(input int max_steps);
    logic [IW-1:0] ins;
    int op, zs, xs, arg, xv, yv, res;
    bit wr;
    foreach (m_regs[i]) m_regs[i] = 0;
    m_pc = 0; m_z = 1'b0; m_c = 1'b0; m_steps = 0;
    while (m_steps < max_steps) begin
      ins = imem[m_pc];
      m_steps++;
      op  = int'(ins[19:16]);
      zs  = int'(ins[15:12]);
      xs  = int'(ins[11:8]);
      arg = int'(ins[7:0]);
      xv  = m_regs[xs];
      yv  = m_regs[arg % 16];
      wr  = 1'b1;
      res = 0;
      case (op)
        1: begin res = (xv + yv) % 256; m_c = (xv + yv > 255); end
        2: begin res = (xv - yv + 256) % 256; m_c = (xv < yv); end
        3: begin res = xv & yv; m_c = 1'b0; end
        4: begin res = xv | yv; m_c = 1'b0; end
        5: begin res = xv ^ yv; m_c = 1'b0; end
        6: res = arg;
        default: wr = 1'b0;
      endcase
      if (wr) begin
        if (zs != 0) m_regs[zs] = res;
        m_z = (res == 0);
      end
      if (op == 9) break;
      if (op == 7)                    m_pc = arg;
      else if (op == 8 && xv == 0)    m_pc = arg;
      else                            m_pc = (m_pc + 1) % 256;
    end
  endtask

  task automatic test_reset();
    clear_imem();
    reset_n = 1'b0;
    #3;
    n_checks++;
    if (imem_req !== 1'b0 || pc !== 8'h00 || halted !== 1'b0 || flag_z !== 1'b0 || flag_c !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_state: req=%b pc=%0h halted=%b z=%b c=%b, expected all 0", imem_req, pc, halted, flag_z, flag_c);
    end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      n_fails++;
      $display("FAIL reset_release_req: req=%b addr=%0h, expected req=1 addr=0", imem_req, imem_addr);
    end
  endtask

  task automatic load_basic();
    clear_imem();
    imem[0] = enc(6, 1, 0, 5);
    imem[1] = enc(6, 2, 0, 3);
    imem[2] = enc(1, 3, 1, 2);
    imem[3] = enc(9, 0, 0, 0);
  endtask

  task automatic test_basic(input int delay);
    int sel [3] = '{1, 2, 3};
    int exp [3] = '{5, 3, 8};
    load_basic();
    run_prog(delay, 200);
    n_checks++;
    if (cycles != 4 * (2 + delay)) begin
      n_fails++;
      $display("FAIL basic_cycles(d=%0d): got %0d, expected %0d", delay, cycles, 4 * (2 + delay));
    end
    n_checks++;
    if (pc !== 8'h03 || flag_z !== 1'b0 || flag_c !== 1'b0 || imem_req !== 1'b0) begin
      n_fails++;
      $display("FAIL basic_state(d=%0d): pc=%0h z=%b c=%b req=%b, expected pc=3 z=0 c=0 req=0", delay, pc, flag_z, flag_c, imem_req);
    end
    for (int i = 0; i < 3; i++) begin
      dbg_sel = 4'(sel[i]);
      #1;
      n_checks++;
      if (dbg_data !== 8'(exp[i])) begin
        n_fails++;
        $display("FAIL basic_r%0d(d=%0d): got %0h, expected %0h", sel[i], delay, dbg_data, exp[i]);
      end
    end
  endtask

  task automatic test_carry();
    clear_imem();
    imem[0] = enc(6, 1, 0, 'hFF);
    imem[1] = enc(6, 2, 0, 1);
    imem[2] = enc(1, 3, 1, 2);
    imem[3] = enc(9, 0, 0, 0);
    run_prog(0, 200);
    dbg_sel = 4'd3;
    #1;
    n_checks++;
    if (dbg_data !== 8'h00 || flag_z !== 1'b1 || flag_c !== 1'b1) begin
      n_fails++;
      $display("FAIL carry_add: r3=%0h z=%b c=%b, expected r3=0 z=1 c=1", dbg_data, flag_z, flag_c);
    end
    imem[3] = enc(2, 4, 2, 1);
    imem[4] = enc(9, 0, 0, 0);
    run_prog(0, 200);
    dbg_sel = 4'd4;
    #1;
    n_checks++;
    if (dbg_data !== 8'h02 || flag_z !== 1'b0 || flag_c !== 1'b1) begin
      n_fails++;
      $display("FAIL borrow_sub: r4=%0h z=%b c=%b, expected r4=2 z=0 c=1", dbg_data, flag_z, flag_c);
    end
  endtask

  task automatic test_branch();
    logic [W-1:0] exp_trace [8] = '{8'h00, 8'h10, 8'h11, 8'h12, 8'hFE, 8'hFF, 8'h00, 8'h01};
    clear_imem();
    imem[8'h00] = enc(8, 0, 1, 'h10);
    imem[8'h01] = enc(9, 0, 0, 0);
    imem[8'h10] = enc(6, 1, 0, 7);
    imem[8'h11] = enc(8, 0, 1, 'h40);
    imem[8'h12] = enc(7, 0, 0, 'hFE);
    imem[8'hFE] = enc(0, 0, 0, 0);
    imem[8'hFF] = enc(0, 0, 0, 0);
    run_prog(0, 200);
    n_checks++;
    if (trace.size() != 8) begin
      n_fails++;
      $display("FAIL branch_trace_len: got %0d, expected 8", trace.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (trace[i] !== exp_trace[i]) begin
          n_fails++;
          $display("FAIL branch_trace[%0d]: got %0h, expected %0h", i, trace[i], exp_trace[i]);
        end
      end
    end
    n_checks++;
    if (pc !== 8'h01 || cycles != 16) begin
      n_fails++;
      $display("FAIL branch_end: pc=%0h cycles=%0d, expected pc=1 cycles=16", pc, cycles);
    end
  endtask

  task automatic test_r0_nop12();
    clear_imem();
    imem[0] = enc(6, 0, 0, 9);
    imem[1] = enc(6, 1, 0, 'hFF);
    imem[2] = enc(6, 2, 0, 1);
    imem[3] = enc(1, 3, 1, 2);
    imem[4] = enc(12, 4, 1, 'h25);
    imem[5] = enc(9, 0, 0, 0);
    run_prog(0, 200);
    dbg_sel = 4'd0;
    #1;
    n_checks++;
    if (dbg_data !== 8'h00) begin
      n_fails++;
      $display("FAIL r0_write: got %0h, expected 0", dbg_data);
    end
    dbg_sel = 4'd4;
    #1;
    n_checks++;
    if (dbg_data !== 8'h00 || flag_z !== 1'b1 || flag_c !== 1'b1 || pc !== 8'h05) begin
      n_fails++;
      $display("FAIL op12_nop: r4=%0h z=%b c=%b pc=%0h, expected r4=0 z=1 c=1 pc=5", dbg_data, flag_z, flag_c, pc);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    load_basic();
    ack_delay = 0;
    apply_reset();
    n = 0;
    while (!(imem_req && imem_ack && imem_addr == 8'h02) && n < 20) begin
      @(posedge clock);
      #1;
      n++;
    end
    n_checks++;
    if (n >= 20) begin
      n_fails++;
      $display("FAIL reset_mid_reach: ADD fetch not seen within %0d cycles", n);
    end
    @(posedge clock);
    #1;
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_mid_exec: req=%b, expected 0 in EXEC", imem_req);
    end
    reset_n = 1'b0;
    dbg_sel = 4'd1;
    #1;
    n_checks++;
    if (pc !== 8'h00 || imem_req !== 1'b0 || dbg_data !== 8'h00 || halted !== 1'b0) begin
      n_fails++;
      $display("FAIL reset_mid_async: pc=%0h req=%b r1=%0h halted=%b, expected 0", pc, imem_req, dbg_data, halted);
    end
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    dbg_sel = 4'd3;
    #1;
    n_checks++;
    if (imem_req !== 1'b1 || pc !== 8'h00 || dbg_data !== 8'h00) begin
      n_fails++;
      $display("FAIL reset_mid_release: req=%b pc=%0h r3=%0h, expected req=1 pc=0 r3=0", imem_req, pc, dbg_data);
    end
  endtask

  task automatic test_random();
    int ops [13] = '{0, 1, 2, 3, 4, 5, 6, 6, 6, 12, 15, 1, 2};
    int n, delay;
    for (int p = 0; p < 6; p++) begin
      clear_imem();
      n     = $urandom_range(6, 14);
      delay = $urandom_range(0, 2);
      for (int i = 0; i < n - 1; i++)
        imem[i] = enc(ops[$urandom_range(0, 12)], $urandom_range(0, 15),
                      $urandom_range(0, 15), $urandom_range(0, 255));
      imem[n-1] = enc(9, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 255));
      model_run(500);
      run_prog(delay, 500);
      n_checks++;
      if (cycles != m_steps * (2 + delay) || pc !== 8'(m_pc) || flag_z !== m_z || flag_c !== m_c) begin
        n_fails++;
        $display("FAIL rand%0d_state: cycles=%0d pc=%0h z=%b c=%b, expected cycles=%0d pc=%0h z=%b c=%b",
                 p, cycles, pc, flag_z, flag_c, m_steps * (2 + delay), m_pc, m_z, m_c);
      end
      for (int r = 0; r < 16; r++) begin
        dbg_sel = 4'(r);
        #1;
        n_checks++;
        if (dbg_data !== 8'(m_regs[r])) begin
          n_fails++;
          $display("FAIL rand%0d_r%0d: got %0h, expected %0h", p, r, dbg_data, m_regs[r]);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic(0);
    test_carry();
    test_basic(3);
    test_branch();
    test_r0_nop12();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
# cpu_core

Multi-cycle fetch/execute processor core that replaces the hand-driven top-level instruction stimulus with a self-sequencing datapath. It fetches instructions from an external instruction memory over a req/ack handshake and holds a program counter. It decodes opcodes internally, drives an ALU and a register file, updates zero/carry flags, and supports immediate loads, jumps, conditional branch and halt. It sits at the top of the design, below only the bench or SoC that supplies instruction memory.

## Interface
Parameters:
- W, 8, data word and PC width
- SEL_W, 4, register select width; register count is 2**SEL_W
- OP_W, 4, opcode width
- IW, OP_W+2*SEL_W+W, derived instruction width: {op, z_sel, x_sel, arg}

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- imem_req  out  1  instruction fetch request
- imem_addr  out  W  fetch address, equal to the PC
- imem_ack  in  1  fetch data valid this cycle
- imem_data  in  IW  fetched instruction
- pc  out  W  current program counter
- flag_z  out  1  zero flag
- flag_c  out  1  carry/borrow flag
- halted  out  1  core in HALT state
- dbg_sel  in  SEL_W  debug register read select
- dbg_data  out  W  combinational read of register dbg_sel

## Operation
- Fields: op = imem_data[IW-1 -: OP_W], z_sel, x_sel, arg = low W bits; y_sel = arg[SEL_W-1:0].
- Opcodes: 0 NOP; 1 ADD z=x+y; 2 SUB z=x-y; 3 AND; 4 OR; 5 XOR; 6 LDI z=arg; 7 JMP pc=arg; 8 JZ if x==0 then pc=arg; 9 HALT. Opcodes 10..15 execute as NOP.
- Register 0 reads as zero; writes to it are discarded. Other registers reset to 0.
- All arithmetic is modulo 2**W. ADD: c = carry out. SUB: c = 1 iff x<y (borrow). AND/OR/XOR: c=0. ALU ops and LDI set z = (result==0). NOP, JMP, JZ and HALT leave both flags unchanged.
- PC: non-jump instructions advance it by 1 and wrap from 2**W-1 to 0. A taken JMP/JZ loads arg. A not-taken JZ increments.
- State machine:
  - FETCH: imem_req=1, imem_addr=pc. If imem_ack is sampled high, latch imem_data and go to EXEC; otherwise stay.
  - EXEC: commit the register write, flags and PC in one edge, then go to FETCH. HALT goes to HALTED without changing the PC.
  - HALTED: imem_req=0, halted=1. Exits only on reset.
- imem_ack arriving outside FETCH is ignored.
- imem_req may stay high across consecutive FETCH cycles. It drops in EXEC.

## Timing
- Reset values: state FETCH, pc=0, flag_z=0, flag_c=0, halted=0, all registers 0. imem_req=1 immediately after reset deasserts; it is 0 while reset_n=0.
- Reset asserted mid-fetch or mid-EXEC: outputs go to their reset values asynchronously, and a pending instruction is discarded.
- Throughput: 2 cycles per instruction with zero-wait ack. Each wait cycle adds 1.
- Register write, flags and PC update become visible the cycle after EXEC.
- dbg_data is combinational and reflects writes the cycle after EXEC.
- Register reads in EXEC see values written by the previous instruction; no forwarding is needed.

## Structure
- Package cpu_pkg holds the opcode localparams (OP_NOP..OP_HALT), the state encoding (S_FETCH, S_EXEC, S_HALTED) and field-slicing helpers.
- One sub-module, regfile: 2**SEL_W x W storage, two combinational read ports plus a debug read port, one synchronous write port, async active-low clear, and r0 hardwired to zero.
- ALU and decode are inline in cpu_core.

## Test plan
- Reset, then program LDI r1,5; LDI r2,3; ADD r3,r1,r2; HALT with ack in the same cycle as req: r3=8, z=0, c=0, halted=1 after 8 cycles, pc=3.
- LDI r1,0xFF; LDI r2,1; ADD r3,r1,r2: r3=0x00, z=1, c=1. Then SUB r4,r2,r1: r4=0x02, c=1.
- Ack delayed 3 cycles on each fetch: imem_req and imem_addr held stable; results identical to the zero-wait run; 5 cycles per instruction.
- JZ r0,0x10 taken (pc=0x10); JZ r1 with r1=7 not taken (pc+1); JMP from pc=0xFF region and NOP at pc=0xFF: pc wraps to 0x00.
- LDI r0,9, then read dbg_sel=0: dbg_data=0. Opcode 12 behaves as NOP with flags unchanged.
- reset_n pulsed low during EXEC of ADD r3: r3 stays 0, pc=0, imem_req low during reset and high on the first cycle after release.
